count_reload_ctrl: RTL and testbench

Upstream sequencer for the team's 4-bit loadable up-counter.
- Accepts reload commands (reload value plus terminal value) over a valid/ready handshake and buffers them in a small FIFO.
- Watches the counter's `count` output and drives the counter's `load`/`load_data` inputs, turning the free-running counter into a programmable, command-driven modulo sequencer.
- `load` is combinational, so the counter reloads on the same edge at which it sits at the terminal value.

---
 rtl/count_reload_ctrl.sv | 172 +++++++++++++++++
 tb/tb_count_reload_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/count_reload_ctrl.sv
// count_reload_ctrl: command-driven sequencer for a loadable up-counter.
// Reload commands (reload value + terminal value) are queued in a small
// FIFO. The sequencer watches the counter output and issues a zero-latency
// load of the next reload value when the counter reaches the active
// terminal value.
//
// Optional feature macro: COUNT_RELOAD_REPEAT_EN
//   defined   - with the FIFO empty, the terminal event reloads act_reload
//               and stays in RUN, so the last command repeats indefinitely.
//   undefined - with the FIFO empty, the terminal event issues no load and
//               the FSM returns to IDLE until another command arrives.
// In both builds a terminal event with an empty FIFO sets the sticky underrun.
module count_reload_ctrl #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     cmd_valid,
    input  logic [WIDTH-1:0]         cmd_reload,
    input  logic [WIDTH-1:0]         cmd_term,
    output logic                     cmd_ready,
    input  logic                     enable,
    input  logic [WIDTH-1:0]         count,
    output logic                     load,
    output logic [WIDTH-1:0]         load_data,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     underrun,
    input  logic                     underrun_clr
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] act_term;
    logic [WIDTH-1:0] act_reload;

    logic [WIDTH-1:0] fifo_reload [DEPTH];
    logic [WIDTH-1:0] fifo_term   [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      level;

    logic             fifo_empty;
    logic [WIDTH-1:0] head_reload;
    logic [WIDTH-1:0] head_term;
    logic             push;
    logic             pop;
    logic             start;
    logic             term_hit;
    logic             empty_hit;

    // ready is taken from the registered level only, never from a same-cycle pop
    assign cmd_ready  = (level != FULL_LEVEL);
    assign fifo_level = level;

    // Decode start / terminal events and drive the zero-latency load outputs
    always_comb begin
        // NOTE: every signal written here gets a default first so no latch is inferred.
        load        = 1'b0;
        load_data   = '0;
        fifo_empty  = (level == '0);
        head_reload = fifo_reload[rd_ptr];
        head_term   = fifo_term[rd_ptr];
        push        = cmd_valid && cmd_ready;
        start       = (state == IDLE) && enable && !fifo_empty;
        term_hit    = (state == RUN) && enable && (count == act_term);
        pop         = start || (term_hit && !fifo_empty);
        empty_hit   = term_hit && fifo_empty;
        if (pop) begin
            load      = 1'b1;
            load_data = head_reload;
        end
`ifdef COUNT_RELOAD_REPEAT_EN
        else if (empty_hit) begin
            load      = 1'b1;
            load_data = act_reload;
        end
`endif
    end

    // Command storage: written on push, read at rd_ptr
    always_ff @(posedge clk) begin
        // NOTE: the storage array carries no reset; the reset pointers and level already mark it empty.
        if (push) begin
            fifo_reload[wr_ptr] <= cmd_reload;
            fifo_term[wr_ptr]   <= cmd_term;
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leave level unchanged
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Sequencer FSM with registered busy and active-entry registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            busy       <= 1'b0;
            act_term   <= '0;
            act_reload <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= RUN;
                        busy       <= 1'b1;
                        act_term   <= head_term;
                        act_reload <= head_reload;
                    end
                end
                RUN: begin
                    if (!enable) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (term_hit) begin
                        if (!fifo_empty) begin
                            act_term   <= head_term;
                            act_reload <= head_reload;
                        end else begin
`ifdef COUNT_RELOAD_REPEAT_EN
                            // last command repeats; act stays as it is
                            state <= RUN;
                            busy  <= 1'b1;
`else
                            state <= IDLE;
                            busy  <= 1'b0;
`endif
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Sticky underrun flag; a set in the same cycle wins over a clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            underrun <= 1'b0;
        end else if (empty_hit) begin
            underrun <= 1'b1;
        end else if (underrun_clr) begin
            underrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_count_reload_ctrl.sv
// tb_count_reload_ctrl: table-driven bench for count_reload_ctrl.
// The bench drives count directly, so each row fixes the counter value the
// sequencer sees in that cycle together with the outputs it must produce.
// Rows whose outcome depends on COUNT_RELOAD_REPEAT_EN use the REP constant.
module tb_count_reload_ctrl;

    localparam int WIDTH = 4;
    localparam int DEPTH = 4;
`ifdef COUNT_RELOAD_REPEAT_EN
    localparam int REP = 1;
`else
    localparam int REP = 0;
`endif

    logic             clk;
    logic             reset_n;
    logic             cmd_valid;
    logic [WIDTH-1:0] cmd_reload;
    logic [WIDTH-1:0] cmd_term;
    logic             cmd_ready;
    logic             enable;
    logic [WIDTH-1:0] count;
    logic             load;
    logic [WIDTH-1:0] load_data;
    logic             busy;
    logic [2:0]       fifo_level;
    logic             underrun;
    logic             underrun_clr;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       en;
        logic       cv;
        logic [3:0] rl;
        logic [3:0] tm;
        logic [3:0] cnt;
        logic       clr;
        logic       ld;
        logic [3:0] ldd;
        logic       busy;
        logic [2:0] lvl;
        logic       rdy;
        logic       und;
    } vec_t;

    vec_t vec_a[$];
    vec_t vec_b[$];
    vec_t exp_q[$];

    count_reload_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .cmd_valid    (cmd_valid),
        .cmd_reload   (cmd_reload),
        .cmd_term     (cmd_term),
        .cmd_ready    (cmd_ready),
        .enable       (enable),
        .count        (count),
        .load         (load),
        .load_data    (load_data),
        .busy         (busy),
        .fifo_level   (fifo_level),
        .underrun     (underrun),
        .underrun_clr (underrun_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic vec_t mk(int en, int cv, int rl, int tm, int cnt, int clr,
                                int ld, int ldd, int bsy, int lvl, int rdy, int und);
        vec_t v;
        v.en   = 1'(en);
        v.cv   = 1'(cv);
        v.rl   = 4'(rl);
        v.tm   = 4'(tm);
        v.cnt  = 4'(cnt);
        v.clr  = 1'(clr);
        v.ld   = 1'(ld);
        v.ldd  = 4'(ldd);
        v.busy = 1'(bsy);
        v.lvl  = 3'(lvl);
        v.rdy  = 1'(rdy);
        v.und  = 1'(und);
        return v;
    endfunction

    // Pop the oldest expectation and compare it with the live outputs
    task automatic compare_out(input int row);
        vec_t e;
        e = exp_q.pop_front();
        check($sformatf("row%0d load", row),       32'(load),       32'(e.ld));
        check($sformatf("row%0d load_data", row),  32'(load_data),  32'(e.ldd));
        check($sformatf("row%0d busy", row),       32'(busy),       32'(e.busy));
        check($sformatf("row%0d fifo_level", row), 32'(fifo_level), 32'(e.lvl));
        check($sformatf("row%0d cmd_ready", row),  32'(cmd_ready),  32'(e.rdy));
        check($sformatf("row%0d underrun", row),   32'(underrun),   32'(e.und));
    endtask

    // Drive one row just after the rising edge, sample before the falling edge
    task automatic apply(input vec_t v, input int row);
        @(posedge clk);
        #1;
        enable       = v.en;
        cmd_valid    = v.cv;
        cmd_reload   = v.rl;
        cmd_term     = v.tm;
        count        = v.cnt;
        underrun_clr = v.clr;
        exp_q.push_back(v);
        #3;
        compare_out(row);
    endtask

    initial begin
        reset_n      = 1'b0;
        cmd_valid    = 1'b0;
        cmd_reload   = '0;
        cmd_term     = '0;
        enable       = 1'b0;
        count        = '0;
        underrun_clr = 1'b0;

        // Reset and single command (3,7)
        vec_a.push_back(mk(1,1, 3, 7, 0,0, 0,0,0,0,1,0));
        vec_a.push_back(mk(1,0, 0, 0, 9,0, 1,3,0,1,1,0));
        vec_a.push_back(mk(1,0, 0, 0, 3,0, 0,0,1,0,1,0));
        vec_a.push_back(mk(1,0, 0, 0, 4,0, 0,0,1,0,1,0));
        vec_a.push_back(mk(1,0, 0, 0, 5,0, 0,0,1,0,1,0));
        vec_a.push_back(mk(1,0, 0, 0, 6,0, 0,0,1,0,1,0));
        vec_a.push_back(mk(1,0, 0, 0, 7,0, REP,(REP != 0) ? 3 : 0,1,0,1,0));
        vec_a.push_back(mk(1,0, 0, 0, 8,0, 0,0,REP,0,1,1));
        vec_a.push_back(mk(1,0, 0, 0, 9,1, 0,0,REP,0,1,1));
        vec_a.push_back(mk(0,0, 0, 0, 0,0, 0,0,REP,0,1,0));
        vec_a.push_back(mk(0,0, 0, 0, 0,0, 0,0,0,0,1,0));
        // Chained commands (2,5) (10,12) (0,1)
        vec_a.push_back(mk(1,1, 2, 5, 0,0, 0,0,0,0,1,0));
        vec_a.push_back(mk(1,1,10,12, 0,0, 1,2,0,1,1,0));
        vec_a.push_back(mk(1,1, 0, 1, 2,0, 0,0,1,1,1,0));
        vec_a.push_back(mk(1,0, 0, 0, 3,0, 0,0,1,2,1,0));
        vec_a.push_back(mk(1,0, 0, 0, 4,0, 0,0,1,2,1,0));
        vec_a.push_back(mk(1,0, 0, 0, 5,0, 1,10,1,2,1,0));
        vec_a.push_back(mk(1,0, 0, 0,10,0, 0,0,1,1,1,0));
        vec_a.push_back(mk(1,0, 0, 0,11,0, 0,0,1,1,1,0));
        vec_a.push_back(mk(1,0, 0, 0,12,0, 1,0,1,1,1,0));
        vec_a.push_back(mk(1,0, 0, 0, 0,0, 0,0,1,0,1,0));
        vec_a.push_back(mk(1,0, 0, 0, 1,0, REP,0,1,0,1,0));
        vec_a.push_back(mk(0,0, 0, 0, 2,1, 0,0,REP,0,1,1));
        vec_a.push_back(mk(0,0, 0, 0, 0,0, 0,0,0,0,1,0));
        // FIFO full, rejected push, then push/pop overlap while running
        vec_a.push_back(mk(0,1, 1, 4, 0,0, 0,0,0,0,1,0));
        vec_a.push_back(mk(0,1, 5, 6, 0,0, 0,0,0,1,1,0));
        vec_a.push_back(mk(0,1, 7, 9, 0,0, 0,0,0,2,1,0));
        vec_a.push_back(mk(0,1,11,13, 0,0, 0,0,0,3,1,0));
        vec_a.push_back(mk(0,1, 8, 8, 0,0, 0,0,0,4,0,0));
        vec_a.push_back(mk(0,0, 0, 0, 0,0, 0,0,0,4,0,0));
        vec_a.push_back(mk(1,1, 8, 8, 0,0, 1,1,0,4,0,0));
        vec_a.push_back(mk(1,1, 8, 8, 1,0, 0,0,1,3,1,0));
        vec_a.push_back(mk(1,0, 0, 0, 4,0, 1,5,1,4,0,0));
        vec_a.push_back(mk(1,1, 9, 9, 6,0, 1,7,1,3,1,0));
        vec_a.push_back(mk(1,0, 0, 0, 7,0, 0,0,1,3,1,0));
        vec_a.push_back(mk(1,0, 0, 0, 9,0, 1,11,1,3,1,0));
        vec_a.push_back(mk(1,0, 0, 0,11,0, 0,0,1,2,1,0));

        // Wrap-around terminal (14,2), then next command (6,9)
        vec_b.push_back(mk(1,1,14, 2, 0,0, 0,0,0,0,1,0));
        vec_b.push_back(mk(1,0, 0, 0, 0,0, 1,14,0,1,1,0));
        vec_b.push_back(mk(1,1, 6, 9,14,0, 0,0,1,0,1,0));
        vec_b.push_back(mk(1,0, 0, 0,15,0, 0,0,1,1,1,0));
        vec_b.push_back(mk(1,0, 0, 0, 0,0, 0,0,1,1,1,0));
        vec_b.push_back(mk(1,0, 0, 0, 1,0, 0,0,1,1,1,0));
        vec_b.push_back(mk(1,0, 0, 0, 2,0, 1,6,1,1,1,0));
        // Enable dropped exactly at the terminal value
        vec_b.push_back(mk(1,1, 3, 3, 6,0, 0,0,1,0,1,0));
        vec_b.push_back(mk(1,0, 0, 0, 7,0, 0,0,1,1,1,0));
        vec_b.push_back(mk(0,0, 0, 0, 9,0, 0,0,1,1,1,0));
        vec_b.push_back(mk(0,0, 0, 0,10,0, 0,0,0,1,1,0));
        // Restart with reload == term, underrun set beats clear
        vec_b.push_back(mk(1,0, 0, 0,10,0, 1,3,0,1,1,0));
        vec_b.push_back(mk(1,0, 0, 0, 3,1, REP,(REP != 0) ? 3 : 0,1,0,1,0));
        vec_b.push_back(mk(0,0, 0, 0, 4,0, 0,0,REP,0,1,1));
        vec_b.push_back(mk(0,0, 0, 0, 0,1, 0,0,0,0,1,1));
        vec_b.push_back(mk(0,0, 0, 0, 0,0, 0,0,0,0,1,0));

        // Reset values while reset is held
        #12;
        check("reset load",       32'(load),       32'd0);
        check("reset load_data",  32'(load_data),  32'd0);
        check("reset busy",       32'(busy),       32'd0);
        check("reset fifo_level", 32'(fifo_level), 32'd0);
        check("reset cmd_ready",  32'(cmd_ready),  32'd1);
        check("reset underrun",   32'(underrun),   32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < vec_a.size(); i++) begin
            apply(vec_a[i], i);
        end

        // Asynchronous reset in RUN with two entries queued and load asserted
        @(posedge clk);
        #1;
        enable    = 1'b1;
        cmd_valid = 1'b0;
        count     = 4'd13;
        #2;
        check("pre-reset load",      32'(load),       32'd1);
        check("pre-reset load_data", 32'(load_data),  32'd8);
        check("pre-reset level",     32'(fifo_level), 32'd2);
        #1;
        reset_n = 1'b0;
        #1;
        check("async reset load",       32'(load),       32'd0);
        check("async reset load_data",  32'(load_data),  32'd0);
        check("async reset busy",       32'(busy),       32'd0);
        check("async reset fifo_level", 32'(fifo_level), 32'd0);
        check("async reset cmd_ready",  32'(cmd_ready),  32'd1);
        enable = 1'b0;
        count  = '0;
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < vec_b.size(); i++) begin
            apply(vec_b[i], 100 + i);
        end

        check("scoreboard drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
